genesis_pad_poll_scheduler: RTL
===============================

// Module: genesis_pad_poll_scheduler
// PURPOSE
//  Sequences SELECT and sampling for two Genesis pad ports sharing one read engine; ports polled back-to-back per request.
//  Detects SMS/3-button/6-button type per port; publishes decoded buttons atomically per port.
//  Sits between the board pad pins and the core input mux; requests come from vsync or an internal timer.
// PARAMETERS
//  SETTLE_CYC       100     cycles each SELECT level is held; sample taken on last cycle (>=2)
//  COOLDOWN_CYC     100000  min cycles SELECT held high after a sweep (6-btn counter reset, >=1.5 ms)
//  AUTO_PERIOD_CYC  0       internal poll request period in cycles; 0 = disabled
// PORTS
//  iCLK              in   1   system clock
//  iN_RESET          in   1   async active-low reset
//  iPOLL_REQ         in   1   one-cycle poll request pulse
//  iGENPAD1          in   6   port1 pins {C/Start,B/A,Up/Z,Down/Y,Left/X,Right/Mode}, active-low
//  iGENPAD2          in   6   port2 pins, same order
//  oGENPAD1_SELECT   out  1   port1 SELECT
//  oGENPAD2_SELECT   out  1   port2 SELECT
//  oGENPAD1_DECODED  out  12  {Z,Y,X,M,S,C,B,A,U,D,L,R}, active-high
//  oGENPAD2_DECODED  out  12  same
//  oGENPAD1_TYPE     out  2   0 SMS/unknown, 1 3-btn, 2 6-btn, 3 error
//  oGENPAD2_TYPE     out  2   same
//  oBUSY             out  1   high from sweep start through end of cooldown
//  oDONE             out  1   one-cycle pulse after port2 commit
// BEHAVIOUR
//  Reset (async, immediate): SELECTs=1, DECODED=0, TYPE=0, oBUSY=0, oDONE=0, pending=0, FSM=IDLE.
//  FSM: IDLE -> P1 (phases 0..7) -> P2 (phases 0..7) -> COOLDOWN -> IDLE.
//  Phase n drives active port SELECT = (n even ? 1 : 0) for SETTLE_CYC cycles; inactive port SELECT=1.
//  After phase 7 active SELECT returns to 1 in the same cycle the next port/state begins.
//  Sampling (last cycle of phase, inverted pins d=~pin):
//   ph0 (H): C,B,U,D,L,R -> shadow bits 6,5,3,2,1,0.
//   ph1 (L): pin[1:0]==00 -> flag3=1, S,A <- d[5:4]; else flag3=0.
//   ph5 (L): pin[3:0]==0000 -> flag6=1, S,A <- d[5:4]; else flag6=0.
//   ph6 (H): if flag6: Z,Y,X,M <- d[3:0]; C,B re-sampled.
//   ph2,3,4,7: SELECT toggled only, no capture.
//  Commit at end of port's phase 7: TYPE = {flag3,flag6} -> 00:0, 10:1, 11:2, 01:3.
//   type 0/3: bits 11:7,4 forced 0; type 1: bits 11:8 forced 0; DECODED and TYPE update same cycle.
//  oDONE pulses the cycle after port2 commit; oBUSY stays high through COOLDOWN (SELECTs=1).
//  Request sources: iPOLL_REQ OR auto tick (counter wraps at AUTO_PERIOD_CYC-1, free-running from reset).
//  Request in IDLE: sweep starts next cycle (oBUSY=1, P1 phase0).
//  Request while busy: sets single pending bit (further requests merge); pending served on IDLE entry, cleared then.
//  Request same cycle as COOLDOWN end: becomes pending, served on next cycle from IDLE.
//  Shadow flags cleared at each port's phase 0 start; no carry-over between sweeps.
//  Pin change mid-sweep: only last-cycle samples matter; no glitch filtering.
//  Sweep latency, request in IDLE -> oDONE: 1 + 16*SETTLE_CYC + 1 cycles.
// STRUCTURE
//  genesis_pad_pkg: type encodings, decoded bit indices, phase count (8), FSM state enum.
//  Sub-module genesis_pad_capture (x2): shadow regs, flag3/flag6, commit logic;
//   inputs: pins, phase index, sample strobe, start, commit. Top keeps FSM, timers, request logic.
// TESTING
//  6-btn model on port1, Z+Start held, SETTLE_CYC=4 -> TYPE1=2, DECODED1=12'h880, oDONE at cycle 66.
//  3-btn model on port2, A+Right held -> TYPE2=1, DECODED2=12'h011; port1 no pad (pins 1) -> TYPE1=0, 0.
//  SMS pad port1, B+Up held -> TYPE1=0, DECODED1=12'h028; inactive port SELECT=1 throughout.
//  iPOLL_REQ pulsed 3x during sweep -> exactly one extra sweep after COOLDOWN; oDONE count=2.
//  iN_RESET low mid-phase 3 -> all outputs reset values same cycle; no oDONE; fresh sweep on next req.
//  AUTO_PERIOD_CYC=200, no iPOLL_REQ -> sweep starts every 200 cycles unless busy (then pending).

Source files
------------

// File: rtl/genesis_pad_poll_scheduler_pkg.sv
// Shared encodings for the Genesis pad poll scheduler: pad types, decoded bit
// positions, phase sequencing constants and scheduler states.
package genesis_pad_poll_scheduler_pkg;

    localparam int unsigned PIN_W      = 6;
    localparam int unsigned DEC_W      = 12;
    localparam int unsigned NUM_PHASES = 8;
    localparam int unsigned PHASE_W    = 3;

    localparam int unsigned BIT_R = 0;
    localparam int unsigned BIT_L = 1;
    localparam int unsigned BIT_D = 2;
    localparam int unsigned BIT_U = 3;
    localparam int unsigned BIT_A = 4;
    localparam int unsigned BIT_B = 5;
    localparam int unsigned BIT_C = 6;
    localparam int unsigned BIT_S = 7;
    localparam int unsigned BIT_M = 8;
    localparam int unsigned BIT_X = 9;
    localparam int unsigned BIT_Y = 10;
    localparam int unsigned BIT_Z = 11;

    typedef enum logic [1:0] {
        PAD_SMS  = 2'd0,
        PAD_3BTN = 2'd1,
        PAD_6BTN = 2'd2,
        PAD_ERR  = 2'd3
    } padType_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_P1,
        ST_P2,
        ST_COOLDOWN
    } schedState_t;

    function automatic padType_t typeFromFlags(input logic flag3, input logic flag6);
        case ({flag3, flag6})
            2'b10:   return PAD_3BTN;
            2'b11:   return PAD_6BTN;
            2'b01:   return PAD_ERR;
            default: return PAD_SMS;
        endcase
    endfunction

    // Buttons a pad type cannot report are forced to zero at commit.
    function automatic logic [DEC_W-1:0] maskDecoded(input logic [DEC_W-1:0] raw, input padType_t padType);
        logic [DEC_W-1:0] masked;
        masked = raw;
        case (padType)
            PAD_3BTN: masked[BIT_Z:BIT_M] = '0;
            PAD_6BTN: masked = raw;
            default: begin
                masked[BIT_Z:BIT_S] = '0;
                masked[BIT_A]       = 1'b0;
            end
        endcase
        return masked;
    endfunction

endpackage

// File: rtl/genesis_pad_poll_scheduler_if.sv
// Pad pins, SELECT lines, request and published results of the pad poll scheduler.
interface genesis_pad_poll_scheduler_if;
    import genesis_pad_poll_scheduler_pkg::*;

    logic             iPOLL_REQ;
    logic [PIN_W-1:0] iGENPAD1;
    logic [PIN_W-1:0] iGENPAD2;
    logic             oGENPAD1_SELECT;
    logic             oGENPAD2_SELECT;
    logic [DEC_W-1:0] oGENPAD1_DECODED;
    logic [DEC_W-1:0] oGENPAD2_DECODED;
    logic [1:0]       oGENPAD1_TYPE;
    logic [1:0]       oGENPAD2_TYPE;
    logic             oBUSY;
    logic             oDONE;

    modport master (
        output iPOLL_REQ, iGENPAD1, iGENPAD2,
        input  oGENPAD1_SELECT, oGENPAD2_SELECT, oGENPAD1_DECODED, oGENPAD2_DECODED,
        input  oGENPAD1_TYPE, oGENPAD2_TYPE, oBUSY, oDONE
    );

    modport slave (
        input  iPOLL_REQ, iGENPAD1, iGENPAD2,
        output oGENPAD1_SELECT, oGENPAD2_SELECT, oGENPAD1_DECODED, oGENPAD2_DECODED,
        output oGENPAD1_TYPE, oGENPAD2_TYPE, oBUSY, oDONE
    );
endinterface

// File: rtl/genesis_pad_poll_scheduler_capture.sv
// Per-port shadow capture: samples pins on phase-end strobes, detects pad type
// and publishes type plus masked buttons together at commit.
module genesis_pad_poll_scheduler_capture
    import genesis_pad_poll_scheduler_pkg::*;
(
    input  logic               iCLK,
    input  logic               iN_RESET,
    input  logic [PIN_W-1:0]   pins,
    input  logic [PHASE_W-1:0] phase,
    input  logic               sampleStb,
    input  logic               start,
    input  logic               commit,
    output logic [DEC_W-1:0]   decoded,
    output padType_t           padType
);

    logic [DEC_W-1:0] shadow;
    logic [PIN_W-1:0] d;
    logic             flag3;
    logic             flag6;
    padType_t         commitType;

    assign d          = ~pins;
    assign commitType = typeFromFlags(flag3, flag6);

    always_ff @(posedge iCLK or negedge iN_RESET) begin
        if (!iN_RESET) begin
            shadow  <= '0;
            flag3   <= 1'b0;
            flag6   <= 1'b0;
            decoded <= '0;
            padType <= PAD_SMS;
        end else begin
            if (start) begin
                shadow <= '0;
                flag3  <= 1'b0;
                flag6  <= 1'b0;
            end else if (sampleStb) begin
                case (phase)
                    PHASE_W'(0): begin
                        shadow[BIT_C]       <= d[5];
                        shadow[BIT_B]       <= d[4];
                        shadow[BIT_U:BIT_R] <= d[3:0];
                    end
                    PHASE_W'(1): begin
                        flag3 <= (pins[1:0] == 2'b00);
                        if (pins[1:0] == 2'b00) begin
                            shadow[BIT_S] <= d[5];
                            shadow[BIT_A] <= d[4];
                        end
                    end
                    PHASE_W'(5): begin
                        flag6 <= (pins[3:0] == 4'b0000);
                        if (pins[3:0] == 4'b0000) begin
                            shadow[BIT_S] <= d[5];
                            shadow[BIT_A] <= d[4];
                        end
                    end
                    // Extended read: Z/Y/X/Mode appear on the d-pad lines.
                    PHASE_W'(6): begin
                        if (flag6) begin
                            shadow[BIT_Z:BIT_M] <= d[3:0];
                            shadow[BIT_C]       <= d[5];
                            shadow[BIT_B]       <= d[4];
                        end
                    end
                    default: ;
                endcase
            end
            if (commit) begin
                padType <= commitType;
                decoded <= maskDecoded(shadow, commitType);
            end
        end
    end

endmodule

// File: rtl/genesis_pad_poll_scheduler.sv
// Sweeps both Genesis pad ports through the 8-phase SELECT sequence per request,
// then holds SELECT high for a cooldown so 6-button pads reset their counters.
module genesis_pad_poll_scheduler
    import genesis_pad_poll_scheduler_pkg::*;
#(
    parameter int unsigned SETTLE_CYC      = 100,
    parameter int unsigned COOLDOWN_CYC    = 100000,
    parameter int unsigned AUTO_PERIOD_CYC = 0
) (
    input  logic                          iCLK,
    input  logic                          iN_RESET,
    genesis_pad_poll_scheduler_if.slave   pad
);

    localparam int unsigned CNT_MAX = (SETTLE_CYC > COOLDOWN_CYC) ? SETTLE_CYC : COOLDOWN_CYC;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX);

    schedState_t        state;
    logic [PHASE_W-1:0] phase;
    logic [CNT_W-1:0]   cnt;
    logic               sel1;
    logic               sel2;
    logic               busy;
    logic               done;
    logic               pending;
    logic               autoTick;

    logic req;
    logic lastCyc;
    logic lastPhase;
    logic startSweep;
    logic p1Sample;
    logic p2Sample;
    logic p1End;
    logic p2End;
    logic coolEnd;

    logic [DEC_W-1:0] dec1;
    logic [DEC_W-1:0] dec2;
    padType_t         type1;
    padType_t         type2;

    // Free-running request timer; disabled entirely when the period is zero.
    generate
        if (AUTO_PERIOD_CYC > 0) begin : gAuto
            localparam int unsigned AUTO_W = (AUTO_PERIOD_CYC > 1) ? $clog2(AUTO_PERIOD_CYC) : 1;
            logic [AUTO_W-1:0] autoCnt;

            assign autoTick = (autoCnt == AUTO_W'(AUTO_PERIOD_CYC - 1));

            always_ff @(posedge iCLK or negedge iN_RESET) begin
                if (!iN_RESET) begin
                    autoCnt <= '0;
                end else if (autoTick) begin
                    autoCnt <= '0;
                end else begin
                    autoCnt <= autoCnt + AUTO_W'(1);
                end
            end
        end else begin : gNoAuto
            assign autoTick = 1'b0;
        end
    endgenerate

    always_comb begin
        req        = pad.iPOLL_REQ | autoTick;
        lastCyc    = (cnt == CNT_W'(SETTLE_CYC - 1));
        lastPhase  = (phase == PHASE_W'(NUM_PHASES - 1));
        startSweep = (state == ST_IDLE) && (req || pending);
        p1Sample   = (state == ST_P1) && lastCyc;
        p2Sample   = (state == ST_P2) && lastCyc;
        p1End      = p1Sample && lastPhase;
        p2End      = p2Sample && lastPhase;
        coolEnd    = (state == ST_COOLDOWN) && (cnt == CNT_W'(COOLDOWN_CYC - 1));
    end

    always_ff @(posedge iCLK or negedge iN_RESET) begin
        if (!iN_RESET) begin
            state   <= ST_IDLE;
            phase   <= '0;
            cnt     <= '0;
            sel1    <= 1'b1;
            sel2    <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b0;
            pending <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state != ST_IDLE && req) begin
                pending <= 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    if (startSweep) begin
                        state   <= ST_P1;
                        phase   <= '0;
                        cnt     <= '0;
                        busy    <= 1'b1;
                        pending <= 1'b0;
                    end
                end
                ST_P1, ST_P2: begin
                    if (lastCyc) begin
                        cnt <= '0;
                        if (lastPhase) begin
                            phase <= '0;
                            sel1  <= 1'b1;
                            sel2  <= 1'b1;
                            state <= (state == ST_P1) ? ST_P2 : ST_COOLDOWN;
                        end else begin
                            // Next phase is even (SELECT high) exactly when this one is odd.
                            phase <= phase + PHASE_W'(1);
                            if (state == ST_P1) begin
                                sel1 <= phase[0];
                            end else begin
                                sel2 <= phase[0];
                            end
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_COOLDOWN: begin
                    done <= (cnt == '0);
                    if (coolEnd) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    genesis_pad_poll_scheduler_capture uCapture1 (
        .iCLK      (iCLK),
        .iN_RESET  (iN_RESET),
        .pins      (pad.iGENPAD1),
        .phase     (phase),
        .sampleStb (p1Sample),
        .start     (startSweep),
        .commit    (p1End),
        .decoded   (dec1),
        .padType   (type1)
    );

    genesis_pad_poll_scheduler_capture uCapture2 (
        .iCLK      (iCLK),
        .iN_RESET  (iN_RESET),
        .pins      (pad.iGENPAD2),
        .phase     (phase),
        .sampleStb (p2Sample),
        .start     (p1End),
        .commit    (p2End),
        .decoded   (dec2),
        .padType   (type2)
    );

    assign pad.oGENPAD1_SELECT  = sel1;
    assign pad.oGENPAD2_SELECT  = sel2;
    assign pad.oGENPAD1_DECODED = dec1;
    assign pad.oGENPAD2_DECODED = dec2;
    assign pad.oGENPAD1_TYPE    = type1;
    assign pad.oGENPAD2_TYPE    = type2;
    assign pad.oBUSY            = busy;
    assign pad.oDONE            = done;

endmodule
